conv_lmem_arb: RTL

- Shares the single layer-memory port (`cwr`/`crd`/`csel`/`caddr_*`/`cdata_*`) between two requesters inside CONV.
  - Requester 0: conv engine; writes layer-0 results, csel=3'b001.
  - Requester 1: max-pool engine; reads layer 0, writes layer 1 at csel=3'b011.
- Issues at most one memory command per cycle.
- Round-robin arbitration with a bounded lock for 2x2 pooling bursts.
- Registered memory-side outputs; returns read data to the requester that issued the read.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_rr_lock.sv | 67 ++++++
 rtl/conv_lmem_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants, requester id type and command type for the CONV layer-memory arbiter.
package conv_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 20;
  localparam int SW_DEF = 3;

  localparam logic [SW_DEF-1:0] CSEL_L0 = 3'b001;
  localparam logic [SW_DEF-1:0] CSEL_L1 = 3'b011;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic              we;
    logic [SW_DEF-1:0] sel;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_cmd_t;

  function automatic req_id_t other_req(input req_id_t r);
    return (r == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/conv_rr_lock.sv
// Two-way round-robin grant with a bounded lock: a locked owner keeps the grant
// until it drops lock/vld, or until LOCK_MAX locked grants elapse while the other waits.
module conv_rr_lock
  import conv_pkg::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] vld,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  req_id_t       ptr;
  req_id_t       owner;
  req_id_t       win;
  logic          own_vld;
  logic          any;
  logic          hold;
  logic          expire;
  logic          held;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // An expired lock hands exactly one grant to the waiter; the owner may re-win afterwards via RR.
  always_comb begin
    any    = |vld;
    hold   = own_vld & vld[owner] & lock[owner];
    expire = hold & (cnt >= CW'(LOCK_MAX)) & vld[other_req(owner)];
    held   = hold & ~expire;
    win    = ptr;
    if (held)
      win = owner;
    else if (expire)
      win = other_req(owner);
    else if (vld[REQ0] && !vld[REQ1])
      win = REQ0;
    else if (vld[REQ1] && !vld[REQ0])
      win = REQ1;
    gnt = '0;
    if (any)
      gnt[win] = 1'b1;
    cnt_next = '0;
    if (any && lock[win])
      cnt_next = (held ? cnt : '0) + CW'(vld[other_req(win)]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= REQ0;
      owner   <= REQ0;
      own_vld <= 1'b0;
      cnt     <= '0;
    end else begin
      if (any) begin
        ptr   <= other_req(win);
        owner <= win;
      end
      own_vld <= any & lock[win];
      cnt     <= cnt_next;
    end
  end

endmodule

// File: rtl/conv_lmem_arb.sv
// Layer-memory port arbiter for CONV: conv engine (r0) and max-pool engine (r1) share one port.
// Optional CONV_ARB_PERF_EN adds saturating grant/stall counters.
module conv_lmem_arb
  import conv_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int SW       = SW_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_vld,
  input  logic          r0_we,
  input  logic [SW-1:0] r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvld,
  input  logic          r1_vld,
  input  logic          r1_we,
  input  logic [SW-1:0] r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvld,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic          crd,
  output logic [SW-1:0] csel,
  output logic [AW-1:0] caddr_wr,
  output logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_wr,
  input  logic [DW-1:0] cdata_rd
`ifdef CONV_ARB_PERF_EN
  ,
  output logic [23:0]   perf_gnt0,
  output logic [23:0]   perf_gnt1,
  output logic [23:0]   perf_stall
`endif
);

  logic [1:0] raw_gnt;
  logic [1:0] gnt;
  logic       any_gnt;
  req_id_t    gnt_id;
  mem_cmd_t   cmd;
  req_id_t    rd_id;
  logic       ret_vld;
  req_id_t    ret_id;

  conv_rr_lock #(
    .LOCK_MAX(LOCK_MAX)
  ) u_rr (
    .clk  (clk),
    .reset(reset),
    .vld  ({r1_vld, r0_vld}),
    .lock ({r1_lock, r0_lock}),
    .gnt  (raw_gnt)
  );

  // Grants are masked by reset so nothing is accepted while the arbiter is held in reset.
  always_comb begin
    gnt     = raw_gnt & {2{reset}};
    any_gnt = |gnt;
    gnt_id  = gnt[1] ? REQ1 : REQ0;
    if (gnt[1]) begin
      cmd.we    = r1_we;
      cmd.sel   = r1_sel;
      cmd.addr  = r1_addr;
      cmd.wdata = r1_wdata;
    end else begin
      cmd.we    = r0_we;
      cmd.sel   = r0_sel;
      cmd.addr  = r0_addr;
      cmd.wdata = r0_wdata;
    end
  end

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr      <= 1'b0;
      crd      <= 1'b0;
      csel     <= '0;
      caddr_wr <= '0;
      caddr_rd <= '0;
      cdata_wr <= '0;
      rd_id    <= REQ0;
    end else begin
      cwr <= any_gnt & cmd.we;
      crd <= any_gnt & ~cmd.we;
      if (any_gnt) begin
        csel  <= cmd.sel;
        rd_id <= gnt_id;
        if (cmd.we) begin
          caddr_wr <= cmd.addr;
          cdata_wr <= cmd.wdata;
        end else begin
          caddr_rd <= cmd.addr;
        end
      end
    end
  end

  // Memory drives cdata_rd on the negedge of the crd cycle, so it is stable at the closing posedge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_vld <= 1'b0;
      ret_id  <= REQ0;
      rdata   <= '0;
    end else begin
      ret_vld <= crd;
      ret_id  <= rd_id;
      if (crd)
        rdata <= cdata_rd;
    end
  end

  assign r0_rvld = ret_vld & (ret_id == REQ0);
  assign r1_rvld = ret_vld & (ret_id == REQ1);

`ifdef CONV_ARB_PERF_EN
  logic stall;

  assign stall = (r0_vld & ~gnt[0]) | (r1_vld & ~gnt[1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (gnt[0] && (perf_gnt0 != '1))
        perf_gnt0 <= perf_gnt0 + 24'd1;
      if (gnt[1] && (perf_gnt1 != '1))
        perf_gnt1 <= perf_gnt1 + 24'd1;
      if (stall && (perf_stall != '1))
        perf_stall <= perf_stall + 24'd1;
    end
  end
`endif

endmodule
